// File: rtl/rng_pkg.sv
// Shared constants and helpers for the pseudo-random tile-position source.
package rng_pkg;

  localparam int NUM_WIDTH  = 4;
  localparam int LFSR_WIDTH = 16;
  // x^16 + x^14 + x^13 + x^11 + 1, maximal-length Galois mask
  localparam logic [LFSR_WIDTH-1:0] TAPS = 16'hB400;
  localparam logic [LFSR_WIDTH-1:0] SEED = 16'hACE1;

  // XOR of all NUM_WIDTH-bit slices of the LFSR state
  function automatic logic [NUM_WIDTH-1:0] fold_xor(input logic [LFSR_WIDTH-1:0] state);
    logic [NUM_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < LFSR_WIDTH / NUM_WIDTH; i++) begin
      acc = acc ^ state[i*NUM_WIDTH +: NUM_WIDTH];
    end
    return acc;
  endfunction

endpackage

// File: rtl/random_num_gen_lfsr_core.sv
// Free-running Galois LFSR with synchronous seed load and all-zero lockup recovery.
module lfsr_core #(
  parameter int                    LFSR_WIDTH = rng_pkg::LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = rng_pkg::TAPS,
  parameter logic [LFSR_WIDTH-1:0] SEED       = rng_pkg::SEED
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [LFSR_WIDTH-1:0] state_o
);

  // A zero seed would lock the register, so it is replaced by 1.
  localparam logic [LFSR_WIDTH-1:0] SEED_SAFE =
    (SEED != '0) ? SEED : LFSR_WIDTH'(1);

  // Power-up value matches the reset value so the FPGA starts in a valid state.
  logic [LFSR_WIDTH-1:0] lfsr_q = SEED_SAFE;
  logic [LFSR_WIDTH-1:0] lfsr_next;

  // Next state: right-shift Galois step, or reload the seed if the register is zero.
  always_comb begin
    lfsr_next = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_next = (lfsr_q >> 1) ^ TAPS;
    end
    if (lfsr_q == '0) begin
      lfsr_next = SEED_SAFE;
    end
  end

  // State register; reset has priority over stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED_SAFE;
    end else begin
      lfsr_q <= lfsr_next;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/random_num_gen.sv
// Pseudo-random board-cell selector: LFSR state XOR-folded down to NUM_WIDTH bits.
module random_num_gen #(
  parameter int                    NUM_WIDTH  = rng_pkg::NUM_WIDTH,
  parameter int                    LFSR_WIDTH = rng_pkg::LFSR_WIDTH,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = rng_pkg::TAPS,
  parameter logic [LFSR_WIDTH-1:0] SEED       = rng_pkg::SEED
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [NUM_WIDTH-1:0] num
);

  import rng_pkg::fold_xor;

  localparam int SLICES = (NUM_WIDTH >= 1) ? (LFSR_WIDTH / NUM_WIDTH) : 1;

  // The fold needs whole slices and at least one output bit.
  generate
    if (NUM_WIDTH < 1) begin : g_bad_num_width
      $error("random_num_gen: NUM_WIDTH must be at least 1");
    end else if ((LFSR_WIDTH % NUM_WIDTH) != 0) begin : g_bad_ratio
      $error("random_num_gen: LFSR_WIDTH must be a multiple of NUM_WIDTH");
    end
  endgenerate

  logic [LFSR_WIDTH-1:0] state;

  lfsr_core #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .TAPS       (TAPS),
    .SEED       (SEED)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .state_o (state)
  );

  // num is combinational from the register only, so it changes just after clk edges.
  generate
    if (NUM_WIDTH == rng_pkg::NUM_WIDTH && LFSR_WIDTH == rng_pkg::LFSR_WIDTH) begin : g_fold_default
      always_comb begin
        num = fold_xor(state);
      end
    end else begin : g_fold_generic
      logic [NUM_WIDTH-1:0] slice [SLICES];
      for (genvar gi = 0; gi < SLICES; gi++) begin : g_slice
        assign slice[gi] = state[gi*NUM_WIDTH +: NUM_WIDTH];
      end
      // Generic XOR reduction across slices for non-default widths.
      always_comb begin
        num = '0;
        for (int i = 0; i < SLICES; i++) begin
          num = num ^ slice[i];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_random_num_gen.sv
// Scoreboard bench for random_num_gen: driver queues expected values, monitor compares.
module tb_random_num_gen;

  logic       clk;
  logic       rst;
  logic [3:0] num;
  logic [3:0] num0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] st;
    logic [3:0]  nm;
    bit          chk0;
    logic [15:0] st0;
    logic [3:0]  nm0;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  random_num_gen dut (
    .clk (clk),
    .rst (rst),
    .num (num)
  );

  random_num_gen #(.SEED(16'h0000)) dut0 (
    .clk (clk),
    .rst (rst),
    .num (num0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Push an expectation for the value the DUT holds during the current cycle.
  task automatic expect_now(input string name, input logic [15:0] st, input logic [3:0] nm,
                            input bit chk0, input logic [15:0] st0, input logic [3:0] nm0);
    exp_t e;
    e.st = st; e.nm = nm; e.chk0 = chk0; e.st0 = st0; e.nm0 = nm0; e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: one comparison set per queued transaction, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        $display("txn %s: state %h num %h (exp %h/%h)", e.name, dut.u_core.lfsr_q, num, e.st, e.nm);
        check({e.name, ".state"}, 32'(dut.u_core.lfsr_q), 32'(e.st));
        check({e.name, ".num"}, 32'(num), 32'(e.nm));
        if (e.chk0) begin
          check({e.name, ".seed0_state"}, 32'(dut0.u_core.lfsr_q), 32'(e.st0));
          check({e.name, ".seed0_num"}, 32'(num0), 32'(e.nm0));
        end
      end
    end
  end

  function automatic logic [15:0] model_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  bit          seen [65536];
  int          counts [16];
  logic [15:0] m;
  logic [15:0] s;
  int          model_miss;
  int          zero_hits;
  int          dup_hits;
  int          early_hits;

  initial begin
    rst = 1'b1;

    // Reset and first steps, both the default and the zero-seed instance.
    next_cycle();
    rst = 1'b0;
    expect_now("reset", 16'hACE1, 4'h9, 1'b1, 16'h0001, 4'h1);
    next_cycle();
    expect_now("step1", 16'hE270, 4'hB, 1'b1, 16'hB400, 4'hF);
    next_cycle();
    expect_now("step2", 16'h7138, 4'hD, 1'b0, 16'h0, 4'h0);
    next_cycle();

    // Full period, distribution and uniqueness from a fresh reset.
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    m = 16'hACE1;
    model_miss = 0; zero_hits = 0; dup_hits = 0; early_hits = 0;
    for (int i = 0; i < 16; i++) counts[i] = 0;
    for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
    for (int k = 0; k <= 65535; k++) begin
      s = dut.u_core.lfsr_q;
      if (k < 65535) begin
        if (s !== m) model_miss++;
        if (s == 16'h0) zero_hits++;
        if (seen[s]) dup_hits++;
        seen[s] = 1'b1;
        counts[num]++;
        if (k > 0 && s == 16'hACE1) early_hits++;
      end else begin
        check("period_return", 32'(s), 32'hACE1);
      end
      m = model_step(m);
      if (k < 65535) next_cycle();
    end
    check("period_model_mismatches", 32'(model_miss), 32'd0);
    check("period_zero_states", 32'(zero_hits), 32'd0);
    check("period_duplicates", 32'(dup_hits), 32'd0);
    check("period_early_return", 32'(early_hits), 32'd0);
    for (int v = 0; v < 16; v++) begin
      check($sformatf("dist_num_%0d", v), 32'(counts[v]), (v == 0) ? 32'd4095 : 32'd4096);
    end

    // Mid-sequence reset held for three cycles.
    repeat (1000) next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      expect_now($sformatf("midrst_hold%0d", i), 16'hACE1, 4'h9, 1'b1, 16'h0001, 4'h1);
    end
    rst = 1'b0;
    next_cycle();
    expect_now("midrst_step1", 16'hE270, 4'hB, 1'b1, 16'hB400, 4'hF);
    next_cycle();
    expect_now("midrst_step2", 16'h7138, 4'hD, 1'b0, 16'h0, 4'h0);

    // Lockup recovery from a forced all-zero state.
    next_cycle();
    force dut.u_core.lfsr_q = 16'h0000;
    expect_now("forced_zero", 16'h0000, 4'h0, 1'b0, 16'h0, 4'h0);
    @(negedge clk);
    #1;
    release dut.u_core.lfsr_q;
    next_cycle();
    expect_now("lockup_recover", 16'hACE1, 4'h9, 1'b0, 16'h0, 4'h0);
    next_cycle();
    expect_now("lockup_step1", 16'hE270, 4'hB, 1'b0, 16'h0, 4'h0);

    // Drain the scoreboard within a bounded number of cycles.
    repeat (4) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
